// File: rtl/i2c_tx_fifo.sv
// ---------------------------------------------------------------------------
// i2c_tx_fifo
//
// This is the transmit FIFO between the APB register block and the I2C master
// byte engine. The register block and the core drive level enables. Each
// enable is edge-detected, so every assertion of a level gives exactly one
// push or one pop.
//
// Configuration macro: I2C_TX_FIFO_FWFT_EN
//   defined   : first-word-fall-through. data_o shows mem[rd_ptr] while the
//               FIFO is non-empty and shows 0 while it is empty.
//   undefined : standard mode. data_o is a register loaded with the popped
//               entry when a pop is accepted, and it holds its value otherwise.
//
// Ports
//   pclk_i          clock, rising edge
//   preset_i        synchronous active-high reset (also clears sticky flags)
//   clear_i         synchronous flush: pointers, count and data_o go to 0
//   data_i          byte to push
//   write_enable_i  level push request; a rising edge pushes
//   read_enable_i   level pop request; a rising edge pops
//   data_o          byte presented to the core
//   empty_o/full_o  decoded from the occupancy register
//   count_o         occupancy, 0 .. 2**ADDR_WIDTH
//   overflow_o      sticky: a push was dropped because the FIFO was full
//   underflow_o     sticky: a pop was ignored because the FIFO was empty
// ---------------------------------------------------------------------------
module i2c_tx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  pclk_i,
  input  logic                  preset_i,
  input  logic                  clear_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  write_enable_i,
  input  logic                  read_enable_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
`ifndef I2C_TX_FIFO_FWFT_EN
  logic [DATA_WIDTH-1:0] data_q, data_d;
`endif

  logic wr_pulse, rd_pulse;
  logic push_acc, pop_acc;
  logic mem_we;
  logic empty, full;

  assign empty = (count_q == '0);
  assign full  = count_q[ADDR_WIDTH];

  // NOTE: every variable assigned here gets a default at the top of the
  // block. Without that default, a path that skips an assignment would infer
  // a latch.
  always_comb begin
    wr_pulse    = write_enable_i & ~wr_q;
    rd_pulse    = read_enable_i & ~rd_q;
    pop_acc     = rd_pulse & ~empty;
    // When the FIFO is full, a push is still accepted if a pop frees a slot
    // in the same cycle.
    push_acc    = wr_pulse & (~full | pop_acc);

    // The edge detectors keep tracking the enables during clear_i. A level
    // that is still high therefore does not push again after the flush.
    wr_d        = write_enable_i;
    rd_d        = read_enable_i;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    mem_we      = 1'b0;
`ifndef I2C_TX_FIFO_FWFT_EN
    data_d      = data_q;
`endif

    if (clear_i) begin
      // The flush overrides any pulse in this cycle. The sticky flags are
      // left unchanged.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
`ifndef I2C_TX_FIFO_FWFT_EN
      data_d   = '0;
`endif
    end else begin
      if (push_acc) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
      end
      if (pop_acc) begin
        rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
`ifndef I2C_TX_FIFO_FWFT_EN
        // This reads the entry before any same-cycle write lands. That
        // ordering matters when the FIFO is full and wr_ptr equals rd_ptr.
        data_d   = mem[rd_ptr_q];
`endif
      end
      unique case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
        default: count_d = count_q;
      endcase
      if (wr_pulse && !push_acc) overflow_d  = 1'b1;
      if (rd_pulse && empty)     underflow_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then sample their _d values from the same edge, and the result does not
  // depend on the order of the statements.
  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      wr_q        <= 1'b0;
      rd_q        <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
`ifndef I2C_TX_FIFO_FWFT_EN
      data_q      <= '0;
`endif
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
`ifndef I2C_TX_FIFO_FWFT_EN
      data_q      <= data_d;
`endif
    end
  end

  // NOTE: the storage array has no reset. The pointers and the count decide
  // which entries are live, so stale contents can never be read. Leaving the
  // reset off also lets the array map onto plain registers without reset.
  always_ff @(posedge pclk_i) begin
    if (mem_we) mem[wr_ptr_q] <= data_i;
  end

`ifdef I2C_TX_FIFO_FWFT_EN
  assign data_o = empty ? '0 : mem[rd_ptr_q];
`else
  assign data_o = data_q;
`endif

  assign empty_o     = empty;
  assign full_o      = full;
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;
  assign underflow_o = underflow_q;

endmodule

// File: tb/tb_i2c_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_i2c_tx_fifo
//
// Directed bench for i2c_tx_fifo. Expected values are written by hand. The
// expected data_o follows I2C_TX_FIFO_FWFT_EN, so the same bench works for
// both builds.
// ---------------------------------------------------------------------------
module tb_i2c_tx_fifo;

  logic       pclk_i = 1'b0;
  logic       preset_i;
  logic       clear_i;
  logic [7:0] data_i;
  logic       write_enable_i;
  logic       read_enable_i;
  logic [7:0] data_o;
  logic       empty_o;
  logic       full_o;
  logic [3:0] count_o;
  logic       overflow_o;
  logic       underflow_o;

  int checks = 0;
  int errors = 0;

  i2c_tx_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
    .pclk_i         (pclk_i),
    .preset_i       (preset_i),
    .clear_i        (clear_i),
    .data_i         (data_i),
    .write_enable_i (write_enable_i),
    .read_enable_i  (read_enable_i),
    .data_o         (data_o),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
  );

  always #5 pclk_i = ~pclk_i;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge. Sampling and driving both happen 1 time unit
  // after the edge.
  task automatic step();
    @(posedge pclk_i);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    data_i = d;
    write_enable_i = 1'b1;
    step();
    write_enable_i = 1'b0;
    step();
  endtask

  task automatic pop();
    read_enable_i = 1'b1;
    step();
    read_enable_i = 1'b0;
    step();
  endtask

  task automatic push_pop(input logic [7:0] d);
    data_i = d;
    write_enable_i = 1'b1;
    read_enable_i  = 1'b1;
    step();
    write_enable_i = 1'b0;
    read_enable_i  = 1'b0;
    step();
  endtask

  task automatic do_reset();
    preset_i = 1'b1;
    step();
    step();
    preset_i = 1'b0;
  endtask

  // Pop one entry and check it. In FWFT mode the head shows before the pop.
  // In standard mode the popped value shows after the pop.
  task automatic pop_expect(input string tag, input logic [7:0] exp);
`ifdef I2C_TX_FIFO_FWFT_EN
    check(tag, data_o, exp);
    pop();
`else
    pop();
    check(tag, data_o, exp);
`endif
  endtask

  initial begin
    preset_i = 1'b0;
    clear_i = 1'b0;
    data_i = 8'h00;
    write_enable_i = 1'b0;
    read_enable_i = 1'b0;

    // Reset values
    do_reset();
    step();
    check("rst_data",  data_o,           8'h00);
    check("rst_empty", 8'(empty_o),      8'h01);
    check("rst_full",  8'(full_o),       8'h00);
    check("rst_count", 8'(count_o),      8'h00);
    check("rst_ovf",   8'(overflow_o),   8'h00);
    check("rst_udf",   8'(underflow_o),  8'h00);

    // An enable held for 5 cycles gives exactly one push.
    data_i = 8'hA5;
    write_enable_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    write_enable_i = 1'b0;
    step();
    check("hold_count", 8'(count_o),    8'h01);
    check("hold_empty", 8'(empty_o),    8'h00);
    check("hold_ovf",   8'(overflow_o), 8'h00);
    pop_expect("hold_data", 8'hA5);
    check("hold_drain", 8'(count_o), 8'h00);

    // Fill the FIFO, then push once more to overflow it.
    for (int i = 1; i <= 8; i++) push(8'(i));
    check("fill_full",  8'(full_o),  8'h01);
    check("fill_count", 8'(count_o), 8'h08);
    check("fill_ovf0",  8'(overflow_o), 8'h00);
    push(8'h09);
    check("ovf_flag",  8'(overflow_o), 8'h01);
    check("ovf_count", 8'(count_o),    8'h08);
    for (int i = 1; i <= 8; i++) pop_expect($sformatf("drain_%0d", i), 8'(i));
    check("drain_empty", 8'(empty_o),     8'h01);
    check("drain_udf",   8'(underflow_o), 8'h00);

    // 20 push/pop pairs, so both pointers wrap twice.
    for (int i = 0; i < 20; i++) begin
      push(8'h40 + 8'(i));
      pop_expect($sformatf("wrap_%0d", i), 8'h40 + 8'(i));
    end
    check("wrap_count", 8'(count_o), 8'h00);
    check("wrap_empty", 8'(empty_o), 8'h01);

    // Push and pop in the same cycle while full, then while empty.
    do_reset();
    step();
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    push_pop(8'h55);
    check("sim_full_count", 8'(count_o),    8'h08);
    check("sim_full_ovf",   8'(overflow_o), 8'h00);
    check("sim_full_flag",  8'(full_o),     8'h01);
    for (int i = 1; i < 8; i++) pop_expect($sformatf("sim_drain_%0d", i), 8'h10 + 8'(i));
    pop_expect("sim_drain_new", 8'h55);
    check("sim_drained", 8'(empty_o), 8'h01);
    push_pop(8'h66);
    check("sim_empty_count", 8'(count_o),     8'h01);
    check("sim_empty_udf",   8'(underflow_o), 8'h01);
    pop_expect("sim_empty_data", 8'h66);

    // Clear in the same cycle as a push pulse, with the enable still held
    // high after the clear.
    push(8'h21);
    push(8'h22);
    push(8'h23);
    check("clr_pre_count", 8'(count_o), 8'h03);
    data_i = 8'h77;
    write_enable_i = 1'b1;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    step();
    write_enable_i = 1'b0;
    step();
    check("clr_count", 8'(count_o),     8'h00);
    check("clr_empty", 8'(empty_o),     8'h01);
    check("clr_ovf",   8'(overflow_o),  8'h00);
    check("clr_udf",   8'(underflow_o), 8'h01);
    check("clr_data",  data_o,          8'h00);
    pop_expect("clr_after", 8'h88 & 8'h00);
    check("clr_udf2", 8'(underflow_o), 8'h01);
    push(8'h88);
    pop_expect("clr_next", 8'h88);

    // Data path timing for a single byte.
    push(8'h3C);
`ifdef I2C_TX_FIFO_FWFT_EN
    check("dp_after_push", data_o, 8'h3C);
`else
    check("dp_after_push", data_o, 8'h88);
`endif
    pop();
`ifdef I2C_TX_FIFO_FWFT_EN
    check("dp_after_pop", data_o, 8'h00);
`else
    check("dp_after_pop", data_o, 8'h3C);
`endif
    step();
`ifdef I2C_TX_FIFO_FWFT_EN
    check("dp_hold", data_o, 8'h00);
`else
    check("dp_hold", data_o, 8'h3C);
`endif
    check("dp_count", 8'(count_o), 8'h00);

    // preset_i in the middle of operation wins over clear and both pulses.
    push(8'h99);
    push(8'h9A);
    push(8'h9B);
    pop();
    push(8'h9C);
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    check("pre_full", 8'(full_o), 8'h01);
    push(8'hEE);
    check("pre_ovf", 8'(overflow_o), 8'h01);
    preset_i = 1'b1;
    clear_i = 1'b1;
    write_enable_i = 1'b1;
    read_enable_i = 1'b1;
    step();
    check("prst_count", 8'(count_o),     8'h00);
    check("prst_empty", 8'(empty_o),     8'h01);
    check("prst_full",  8'(full_o),      8'h00);
    check("prst_ovf",   8'(overflow_o),  8'h00);
    check("prst_udf",   8'(underflow_o), 8'h00);
    check("prst_data",  data_o,          8'h00);
    preset_i = 1'b0;
    clear_i = 1'b0;
    write_enable_i = 1'b0;
    read_enable_i = 1'b0;
    step();
    push(8'h5A);
    pop_expect("prst_after", 8'h5A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_tx_fifo.md
# i2c_tx_fifo

Transmit FIFO between the APB register block and the I2C master core. It captures each byte the CPU writes to the transmit register (0x02) and holds it until the core's byte engine pops it for shifting onto SDA. The register block holds its write-enable high for the whole APB access and beyond, so this block edge-detects both enables and converts each level assertion into exactly one push or pop.

## Interface
Parameters:
- DATA_WIDTH, 8, byte width.
- ADDR_WIDTH, 3, log2 of depth; depth = 2**ADDR_WIDTH (8).

Ports:
- pclk_i  input  1  clock; all logic on the rising edge.
- preset_i  input  1  synchronous, active-high reset.
- clear_i  input  1  synchronous flush from the core (stop condition or abort).
- data_i  input  DATA_WIDTH  byte from the transmit register output.
- write_enable_i  input  1  level from the register block's tx FIFO write enable; the rising edge pushes.
- read_enable_i  input  1  level from the core; the rising edge pops.
- data_o  output  DATA_WIDTH  byte presented to the core.
- empty_o  output  1  FIFO holds 0 entries.
- full_o  output  1  FIFO holds 2**ADDR_WIDTH entries.
- count_o  output  ADDR_WIDTH+1  occupancy.
- overflow_o  output  1  sticky: a push was dropped.
- underflow_o  output  1  sticky: a pop was ignored.

## Operation
- The block registers both enables as wr_q and rd_q.
  - wr_pulse = write_enable_i & ~wr_q.
  - rd_pulse = read_enable_i & ~rd_q.
- A level held for N cycles produces exactly one pulse.
- Storage is a register array with wr_ptr and rd_ptr, each ADDR_WIDTH bits.
  - Pointers wrap from 2**ADDR_WIDTH-1 to 0 by natural overflow.
  - count_o is a separate register with saturating range 0..2**ADDR_WIDTH.
- Push accepted = wr_pulse & (~full_o | pop accepted).
  - On accept: mem[wr_ptr] <= data_i and wr_ptr increments.
  - wr_pulse while full with no pop accepted: overflow_o <= 1, nothing stored.
- Pop accepted = rd_pulse & ~empty_o.
  - On accept: rd_ptr increments.
  - rd_pulse while empty: underflow_o <= 1, and pointers and data_o are unchanged.
- Simultaneous pulses:
  - Not empty and not full: both accepted, count unchanged.
  - Full: both accepted, count stays at 2**ADDR_WIDTH, no overflow.
  - Empty: the push is accepted, the pop is ignored with underflow_o set, count becomes 1.
- clear_i:
  - Zeroes wr_ptr, rd_ptr, count_o and data_o.
  - Takes priority over any pulse in the same cycle.
  - Leaves overflow_o and underflow_o unchanged.
  - Does not clear wr_q or rd_q, so an enable still held high does not re-push after the clear.
- Only preset_i clears the sticky flags.
- Memory contents are not reset; stale entries are unreachable.
- empty_o = (count_o == 0) and full_o = count_o[ADDR_WIDTH], both decoded from the count register.

## Timing
- Reset values: data_o 0, empty_o 1, full_o 0, count_o 0, overflow_o 0, underflow_o 0, wr_q 0, rd_q 0, both pointers 0.
- Push:
  - Cycle C is the first cycle with write_enable_i=1 and wr_q=0; the write occurs at the end of C.
  - count_o, empty_o and full_o reflect the push in C+1.
- Pop:
  - rd_pulse is evaluated in cycle C; the pointer and count update at the end of C.
  - The data_o update depends on the configuration macro.
- Enable dropping and re-asserting:
  - Deassert for one cycle then reassert: a second pulse (minimum spacing 2 cycles).
  - Held continuously: no further pulses.
- preset_i mid-operation: all state returns to reset values at the next edge, regardless of clear_i or pulses.

## Configuration
- Macro: I2C_TX_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - data_o is mem[rd_ptr] whenever the FIFO is non-empty; data_o is 0 when empty.
  - After a push into an empty FIFO, data_o is valid in C+1.
  - A pop advances data_o to the next entry in C+1.
- Undefined (standard):
  - data_o is a register loaded with mem[rd_ptr] at the end of the cycle that accepts a pop, valid from C+1.
  - data_o holds its value otherwise, including across pushes and ignored pops.
  - clear_i zeroes data_o.

## Test plan
- Reset, then hold write_enable_i high for 5 cycles with data_i=0xA5 -> exactly one push, count_o=1, empty_o=0, overflow_o=0.
- Push 0x01..0x08, one pulse each -> full_o=1, count_o=8. Ninth pulse with 0x09 -> overflow_o=1, count_o=8. Eight pops return 0x01..0x08 in order, then empty_o=1.
- Run 20 push/pop pairs so both pointers wrap twice -> data order preserved and count_o returns to 0.
- Full FIFO with rd_pulse and wr_pulse in the same cycle -> count_o stays 8, no overflow. Empty FIFO with both pulses -> count_o=1, underflow_o=1.
- Three entries queued, assert clear_i in the same cycle as a wr_pulse -> count_o=0, empty_o=1, flags unchanged, no entry written.
- Run the FWFT and standard builds: push 0x3C into an empty FIFO, then pop.
  - FWFT: data_o=0x3C one cycle after the push, 0 after the pop.
  - Standard: data_o=0x3C one cycle after the pop and held thereafter.
